// File: rtl/txuart_arbiter.sv
// Round-robin arbiter sharing one txuart transmitter among NREQ character sources.
// A grant lasts for a whole message, a MAX_BURST-character burst, or until the owner idles HOLD_TIMEOUT cycles.
module txuart_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [8*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_last,
  output logic [NREQ-1:0]   o_req_busy,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy
);

  localparam int unsigned IW        = $clog2(NREQ);
  localparam logic [7:0]  BURST_END = 8'(MAX_BURST - 1);
  localparam logic [15:0] IDLE_END  = 16'(HOLD_TIMEOUT - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [IW-1:0] last_owner, last_owner_nx;
  logic [7:0]    burst_cnt, burst_cnt_nx;
  logic [15:0]   idle_cnt, idle_cnt_nx;
  logic [IW-1:0] pick, idx;
  logic          found;
  logic [7:0]    req_data [NREQ];

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_data[k] = i_req_data[8*k +: 8];
    end
  end

  // First pending requester after last_owner, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(last_owner) + i) % NREQ);
      if (!found && i_req_stb[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    burst_cnt_nx  = burst_cnt;
    idle_cnt_nx   = idle_cnt;
    o_grant       = '0;
    o_tx_stb      = 1'b0;
    o_tx_data     = '0;
    o_req_busy    = '1;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx     = OWNED;
          owner_nx     = pick;
          burst_cnt_nx = '0;
          idle_cnt_nx  = '0;
        end
      end
      OWNED: begin
        o_grant[owner]    = 1'b1;
        o_tx_stb          = i_req_stb[owner];
        o_tx_data         = req_data[owner];
        o_req_busy[owner] = i_tx_busy;
        if (i_req_stb[owner]) begin
          idle_cnt_nx = '0;
          if (!i_tx_busy) begin
            // The final accept of a grant clears rather than increments, keeping burst_cnt within MAX_BURST-1.
            if (i_req_last[owner] || burst_cnt == BURST_END) begin
              state_nx      = IDLE;
              last_owner_nx = owner;
              burst_cnt_nx  = '0;
            end else begin
              burst_cnt_nx = burst_cnt + 8'd1;
            end
          end
        end else if (idle_cnt == IDLE_END) begin
          state_nx      = IDLE;
          last_owner_nx = owner;
        end else begin
          idle_cnt_nx = idle_cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      burst_cnt  <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      burst_cnt  <= burst_cnt_nx;
      idle_cnt   <= idle_cnt_nx;
    end
  end

endmodule
